lsu_sram_bridge: RTL and testbench

- Load/store unit in the MEM stage. Takes the effective address computed by the ALU, plus the memory opcode and the store data.
- Issues one transaction at a time on the data SRAM-like bus (req / addr_ok / data_ok handshake). Generates byte strobes and replicated store data.
- Sign- or zero-extends load data. Flags misaligned accesses as AdEL/AdES.
- Stalls the pipeline until the access completes.

---
 rtl/lsu_sram_bridge_if.sv | 38 +++
 rtl/lsu_sram_bridge.sv | 259 +++++++++++++++++++++++++
 tb/tb_lsu_sram_bridge.sv | 296 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/lsu_sram_bridge_if.sv
// Data SRAM-like bus between the load/store unit and the data memory.
// The bridge is the master: it issues req with the request fields and
// receives the addr_ok / data_ok handshake and the read data.
interface lsu_sram_bridge_if;
  logic        data_sram_req;
  logic        data_sram_wr;
  logic [1:0]  data_sram_size;
  logic [31:0] data_sram_addr;
  logic [31:0] data_sram_wdata;
  logic [3:0]  data_sram_wstrb;
  logic        data_sram_addr_ok;
  logic        data_sram_data_ok;
  logic [31:0] data_sram_rdata;

  modport master (
    output data_sram_req,
    output data_sram_wr,
    output data_sram_size,
    output data_sram_addr,
    output data_sram_wdata,
    output data_sram_wstrb,
    input  data_sram_addr_ok,
    input  data_sram_data_ok,
    input  data_sram_rdata
  );

  modport slave (
    input  data_sram_req,
    input  data_sram_wr,
    input  data_sram_size,
    input  data_sram_addr,
    input  data_sram_wdata,
    input  data_sram_wstrb,
    output data_sram_addr_ok,
    output data_sram_data_ok,
    output data_sram_rdata
  );
endinterface

// File: rtl/lsu_sram_bridge.sv
// MEM-stage load/store unit. Accepts one memory op at a time from the
// pipeline, checks alignment, formats store strobes/data, runs the
// req / addr_ok / data_ok handshake on the data SRAM bus and returns the
// sign/zero-extended load result. The pipeline is stalled via busy until
// the access completes, and a flush abandons (or drains) the access.
module lsu_sram_bridge #(
  parameter logic [31:0] PHYS_MASK = 32'h1FFF_FFFF
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        req_valid,
  input  logic [7:0]  mem_op,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  input  logic        flush,
  output logic        busy,
  output logic        done,
  output logic [31:0] rdata_ext,
  output logic        adel,
  output logic        ades,
  output logic [31:0] badvaddr,
  lsu_sram_bridge_if.master bus
);

  // Memory opcode encodings shared with the EXE stage.
  localparam logic [7:0] EXE_LB_OP  = 8'b1110_0000;
  localparam logic [7:0] EXE_LBU_OP = 8'b1110_0100;
  localparam logic [7:0] EXE_LH_OP  = 8'b1110_0001;
  localparam logic [7:0] EXE_LHU_OP = 8'b1110_0101;
  localparam logic [7:0] EXE_LW_OP  = 8'b1110_0011;
  localparam logic [7:0] EXE_SB_OP  = 8'b1110_1000;
  localparam logic [7:0] EXE_SH_OP  = 8'b1110_1001;
  localparam logic [7:0] EXE_SW_OP  = 8'b1110_1011;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    REQ   = 3'd1,
    WAIT  = 3'd2,
    DRAIN = 3'd3,
    DONE  = 3'd4
  } state_t;

  state_t      state;
  state_t      next_state;

  logic [7:0]  op_reg;
  logic [31:0] addr_reg;
  logic [31:0] wdata_reg;
  logic [3:0]  wstrb_reg;
  logic [1:0]  size_reg;
  logic        wr_reg;
  logic        load_reg;

  logic        op_known;
  logic        op_load;
  logic        op_misaligned;
  logic [1:0]  op_size;
  logic [3:0]  op_wstrb;
  logic [31:0] op_wdata;

  logic [7:0]  load_byte;
  logic [15:0] load_half;
  logic [31:0] load_ext;

  logic        accept;
  logic        capture_rdata;
  logic        in_req;

  // Decode the incoming op: legality, alignment, bus size, strobes and
  // lane-replicated store data, so the accept cycle can latch them all.
  always_comb begin
    op_known      = 1'b0;
    op_load       = 1'b0;
    op_misaligned = 1'b0;
    op_size       = 2'd0;
    op_wstrb      = 4'b0000;
    op_wdata      = 32'h0000_0000;
    case (mem_op)
      EXE_LB_OP, EXE_LBU_OP: begin
        op_known = 1'b1;
        op_load  = 1'b1;
        op_size  = 2'd0;
      end
      EXE_LH_OP, EXE_LHU_OP: begin
        op_known      = 1'b1;
        op_load       = 1'b1;
        op_size       = 2'd1;
        op_misaligned = addr[0];
      end
      EXE_LW_OP: begin
        op_known      = 1'b1;
        op_load       = 1'b1;
        op_size       = 2'd2;
        op_misaligned = |addr[1:0];
      end
      EXE_SB_OP: begin
        op_known = 1'b1;
        op_size  = 2'd0;
        op_wstrb = 4'b0001 << addr[1:0];
        op_wdata = {4{wdata[7:0]}};
      end
      EXE_SH_OP: begin
        op_known      = 1'b1;
        op_size       = 2'd1;
        op_misaligned = addr[0];
        op_wstrb      = addr[1] ? 4'b1100 : 4'b0011;
        op_wdata      = {2{wdata[15:0]}};
      end
      EXE_SW_OP: begin
        op_known      = 1'b1;
        op_size       = 2'd2;
        op_misaligned = |addr[1:0];
        op_wstrb      = 4'b1111;
        op_wdata      = wdata;
      end
      default: begin
        op_known = 1'b0;
      end
    endcase
  end

  // Pick the addressed byte/half out of the returned word and extend it
  // according to the latched load op.
  always_comb begin
    load_byte = bus.data_sram_rdata[7:0];
    case (addr_reg[1:0])
      2'd0: load_byte = bus.data_sram_rdata[7:0];
      2'd1: load_byte = bus.data_sram_rdata[15:8];
      2'd2: load_byte = bus.data_sram_rdata[23:16];
      2'd3: load_byte = bus.data_sram_rdata[31:24];
      default: load_byte = bus.data_sram_rdata[7:0];
    endcase
    load_half = addr_reg[1] ? bus.data_sram_rdata[31:16] : bus.data_sram_rdata[15:0];
    load_ext  = bus.data_sram_rdata;
    case (op_reg)
      EXE_LB_OP:  load_ext = {{24{load_byte[7]}}, load_byte};
      EXE_LBU_OP: load_ext = {24'h00_0000, load_byte};
      EXE_LH_OP:  load_ext = {{16{load_half[15]}}, load_half};
      EXE_LHU_OP: load_ext = {16'h0000, load_half};
      default:    load_ext = bus.data_sram_rdata;
    endcase
  end

  // Next state, stall and completion. An access that the bus has already
  // accepted must still see its data_ok, so a flush after addr_ok drains
  // instead of returning straight to IDLE.
  always_comb begin
    next_state    = state;
    accept        = 1'b0;
    capture_rdata = 1'b0;
    busy          = 1'b0;
    done          = 1'b0;
    case (state)
      IDLE: begin
        if (req_valid && !flush) begin
          accept = 1'b1;
          busy   = 1'b1;
          if (!op_known || op_misaligned) next_state = DONE;
          else                            next_state = REQ;
        end
      end
      REQ: begin
        busy = 1'b1;
        if (bus.data_sram_addr_ok) begin
          if (bus.data_sram_data_ok) begin
            if (flush) begin
              next_state = IDLE;
            end else begin
              next_state    = DONE;
              capture_rdata = load_reg;
            end
          end else begin
            next_state = flush ? DRAIN : WAIT;
          end
        end else if (flush) begin
          next_state = IDLE;
        end
      end
      WAIT: begin
        busy = 1'b1;
        if (bus.data_sram_data_ok) begin
          if (flush) begin
            next_state = IDLE;
          end else begin
            next_state    = DONE;
            capture_rdata = load_reg;
          end
        end else if (flush) begin
          next_state = DRAIN;
        end
      end
      DRAIN: begin
        busy = 1'b1;
        if (bus.data_sram_data_ok) next_state = IDLE;
      end
      DONE: begin
        done       = ~flush;
        next_state = IDLE;
      end
      default: begin
        next_state = IDLE;
      end
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state <= IDLE;
    else         state <= next_state;
  end

  // Latch the request on accept and the load result on completion; error
  // flags and the result hold until the next accepted request.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      op_reg    <= 8'h00;
      addr_reg  <= 32'h0000_0000;
      wdata_reg <= 32'h0000_0000;
      wstrb_reg <= 4'b0000;
      size_reg  <= 2'd0;
      wr_reg    <= 1'b0;
      load_reg  <= 1'b0;
      adel      <= 1'b0;
      ades      <= 1'b0;
      badvaddr  <= 32'h0000_0000;
      rdata_ext <= 32'h0000_0000;
    end else begin
      if (accept) begin
        op_reg    <= mem_op;
        addr_reg  <= addr;
        wdata_reg <= op_wdata;
        wstrb_reg <= op_wstrb;
        size_reg  <= op_size;
        wr_reg    <= op_known & ~op_load;
        load_reg  <= op_load;
        if (op_known && op_misaligned) begin
          adel     <= op_load;
          ades     <= ~op_load;
          badvaddr <= addr;
        end else begin
          adel <= 1'b0;
          ades <= 1'b0;
        end
      end
      if (capture_rdata) rdata_ext <= load_ext;
    end
  end

  // Request fields come straight from registers and are only driven while
  // the request is outstanding, keeping the bus quiet otherwise.
  assign in_req              = (state == REQ);
  assign bus.data_sram_req   = in_req;
  assign bus.data_sram_wr    = in_req & wr_reg;
  assign bus.data_sram_size  = in_req ? size_reg : 2'd0;
  assign bus.data_sram_addr  = in_req ? (addr_reg & PHYS_MASK) : 32'h0000_0000;
  assign bus.data_sram_wdata = in_req ? wdata_reg : 32'h0000_0000;
  assign bus.data_sram_wstrb = in_req ? wstrb_reg : 4'b0000;

endmodule

// File: tb/tb_lsu_sram_bridge.sv
// Directed scoreboard bench for lsu_sram_bridge. Stimulus tasks push the
// expected bus request and the expected completion result; two monitors
// compare them whenever the DUT presents a request or a done pulse.
module tb_lsu_sram_bridge;

  localparam logic [7:0] LB  = 8'b1110_0000;
  localparam logic [7:0] LBU = 8'b1110_0100;
  localparam logic [7:0] LH  = 8'b1110_0001;
  localparam logic [7:0] LHU = 8'b1110_0101;
  localparam logic [7:0] LW  = 8'b1110_0011;
  localparam logic [7:0] SB  = 8'b1110_1000;
  localparam logic [7:0] SH  = 8'b1110_1001;
  localparam logic [7:0] SW  = 8'b1110_1011;

  typedef struct packed {
    logic [31:0] addr;
    logic        wr;
    logic [1:0]  size;
    logic [3:0]  wstrb;
    logic [31:0] wdata;
  } bus_req_t;

  typedef struct packed {
    logic [31:0] rdata;
    logic        adel;
    logic        ades;
    logic [31:0] badv;
    logic        check_bad;
  } result_t;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        req_valid = 1'b0;
  logic [7:0]  mem_op = 8'h00;
  logic [31:0] addr = 32'h0;
  logic [31:0] wdata = 32'h0;
  logic        flush = 1'b0;
  logic        busy;
  logic        done;
  logic [31:0] rdata_ext;
  logic        adel;
  logic        ades;
  logic [31:0] badvaddr;

  lsu_sram_bridge_if bus ();

  lsu_sram_bridge dut (
    .clk       (clk),
    .resetn    (resetn),
    .req_valid (req_valid),
    .mem_op    (mem_op),
    .addr      (addr),
    .wdata     (wdata),
    .flush     (flush),
    .busy      (busy),
    .done      (done),
    .rdata_ext (rdata_ext),
    .adel      (adel),
    .ades      (ades),
    .badvaddr  (badvaddr),
    .bus       (bus.master)
  );

  always #5 clk = ~clk;

  wire [139:0] all_outs = {busy, done, rdata_ext, adel, ades, badvaddr,
                           bus.data_sram_req, bus.data_sram_wr, bus.data_sram_size,
                           bus.data_sram_addr, bus.data_sram_wdata, bus.data_sram_wstrb};

  int tests_run = 0;
  int tests_failed = 0;
  int busy_count = 0;
  int done_count = 0;
  bus_req_t req_q[$];
  result_t  res_q[$];

  task automatic checkOutput(input string name, input logic [159:0] act, input logic [159:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  function automatic bus_req_t mk_bus(input logic [31:0] a, input logic w, input logic [1:0] s,
                                      input logic [3:0] st, input logic [31:0] wd);
    bus_req_t b;
    b.addr = a; b.wr = w; b.size = s; b.wstrb = st; b.wdata = wd;
    return b;
  endfunction

  function automatic result_t mk_res(input logic [31:0] rd, input logic el, input logic es,
                                     input logic [31:0] bv, input logic chk);
    result_t r;
    r.rdata = rd; r.adel = el; r.ades = es; r.badv = bv; r.check_bad = chk;
    return r;
  endfunction

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  // Monitor: counts busy/done cycles and checks every request cycle and
  // every done pulse against the head of the matching queue.
  initial begin
    bus_req_t eb;
    result_t  er;
    forever begin
      @(negedge clk);
      if (busy) busy_count++;
      if (done) done_count++;
      if (bus.data_sram_req) begin
        if (req_q.size() == 0) begin
          checkOutput("unexpected_req", {159'h0, bus.data_sram_req}, 160'h0);
        end else begin
          eb = req_q[0];
          checkOutput("bus_fields", {bus.data_sram_addr, bus.data_sram_wr, bus.data_sram_size,
                                     bus.data_sram_wstrb, bus.data_sram_wdata}, eb);
          if (bus.data_sram_addr_ok) eb = req_q.pop_front();
        end
      end
      if (done) begin
        if (res_q.size() == 0) begin
          checkOutput("unexpected_done", {159'h0, done}, 160'h0);
        end else begin
          er = res_q.pop_front();
          checkOutput("done_result", {rdata_ext, adel, ades}, {er.rdata, er.adel, er.ades});
          if (er.check_bad) checkOutput("done_badvaddr", badvaddr, er.badv);
        end
      end
    end
  end

  // One complete access. a_dly cycles before addr_ok; d_dly cycles before
  // data_ok (negative means data_ok together with addr_ok). has_req=0 is an
  // access that completes without touching the bus.
  task automatic applyStimulus(input logic [7:0] op, input logic [31:0] a, input logic [31:0] wd,
                               input int a_dly, input int d_dly, input logic [31:0] rd,
                               input bit has_req, input bus_req_t eb, input result_t er);
    if (has_req) req_q.push_back(eb);
    res_q.push_back(er);
    req_valid = 1'b1; mem_op = op; addr = a; wdata = wd;
    cycle();
    if (has_req) begin
      repeat (a_dly) cycle();
      bus.data_sram_addr_ok = 1'b1;
      if (d_dly < 0) begin
        bus.data_sram_data_ok = 1'b1;
        bus.data_sram_rdata   = rd;
      end
      cycle();
      bus.data_sram_addr_ok = 1'b0;
      if (d_dly >= 0) begin
        bus.data_sram_data_ok = 1'b0;
        repeat (d_dly) cycle();
        bus.data_sram_data_ok = 1'b1;
        bus.data_sram_rdata   = rd;
        cycle();
      end
      bus.data_sram_data_ok = 1'b0;
    end
    req_valid = 1'b0;
    cycle();
  endtask

  initial begin
    int b0;
    int d0;
    bus.data_sram_addr_ok = 1'b0;
    bus.data_sram_data_ok = 1'b0;
    bus.data_sram_rdata   = 32'h0;

    repeat (2) @(posedge clk);
    @(negedge clk);
    checkOutput("reset_outputs", all_outs, 160'h0);
    @(posedge clk); #1;
    resetn = 1'b1;
    cycle();
    @(negedge clk);
    checkOutput("idle_outputs", all_outs, 160'h0);
    cycle();

    $display("[TB] byte loads");
    applyStimulus(LB, 32'h8000_0003, 32'h0, 0, 0, 32'h80FF_1234, 1'b1,
                  mk_bus(32'h0000_0003, 1'b0, 2'd0, 4'b0000, 32'h0),
                  mk_res(32'hFFFF_FF80, 1'b0, 1'b0, 32'h0, 1'b0));
    b0 = busy_count; d0 = done_count;
    applyStimulus(LBU, 32'h8000_0003, 32'h0, 0, 0, 32'h80FF_1234, 1'b1,
                  mk_bus(32'h0000_0003, 1'b0, 2'd0, 4'b0000, 32'h0),
                  mk_res(32'h0000_0080, 1'b0, 1'b0, 32'h0, 1'b0));
    checkOutput("best_case_busy_cycles", busy_count - b0, 3);
    checkOutput("best_case_done_pulses", done_count - d0, 1);

    $display("[TB] halfword store");
    applyStimulus(SH, 32'hA000_0002, 32'h1234_BEEF, 0, 0, 32'h0, 1'b1,
                  mk_bus(32'h0000_0002, 1'b1, 2'd1, 4'b1100, 32'hBEEF_BEEF),
                  mk_res(32'h0000_0080, 1'b0, 1'b0, 32'h0, 1'b0));

    $display("[TB] misaligned and unknown ops");
    applyStimulus(LW, 32'h8000_0006, 32'h0, 0, 0, 32'h0, 1'b0, mk_bus(32'h0, 1'b0, 2'd0, 4'h0, 32'h0),
                  mk_res(32'h0000_0080, 1'b1, 1'b0, 32'h8000_0006, 1'b1));
    applyStimulus(SW, 32'h8000_0006, 32'h5555_AAAA, 0, 0, 32'h0, 1'b0, mk_bus(32'h0, 1'b0, 2'd0, 4'h0, 32'h0),
                  mk_res(32'h0000_0080, 1'b0, 1'b1, 32'h8000_0006, 1'b1));
    applyStimulus(8'h00, 32'h8000_0001, 32'h0, 0, 0, 32'h0, 1'b0, mk_bus(32'h0, 1'b0, 2'd0, 4'h0, 32'h0),
                  mk_res(32'h0000_0080, 1'b0, 1'b0, 32'h0, 1'b0));

    $display("[TB] delayed handshake");
    b0 = busy_count; d0 = done_count;
    applyStimulus(LH, 32'h0000_0000, 32'h0, 3, 2, 32'h0000_8001, 1'b1,
                  mk_bus(32'h0000_0000, 1'b0, 2'd1, 4'b0000, 32'h0),
                  mk_res(32'hFFFF_8001, 1'b0, 1'b0, 32'h0, 1'b0));
    checkOutput("delayed_busy_cycles", busy_count - b0, 8);
    checkOutput("delayed_done_pulses", done_count - d0, 1);

    $display("[TB] addr_ok and data_ok together");
    b0 = busy_count;
    applyStimulus(LHU, 32'h8000_0002, 32'h0, 0, -1, 32'h8001_ABCD, 1'b1,
                  mk_bus(32'h0000_0002, 1'b0, 2'd1, 4'b0000, 32'h0),
                  mk_res(32'h0000_8001, 1'b0, 1'b0, 32'h0, 1'b0));
    checkOutput("same_cycle_busy_cycles", busy_count - b0, 2);
    applyStimulus(SW, 32'h8000_0008, 32'hCAFE_F00D, 1, 1, 32'h0, 1'b1,
                  mk_bus(32'h0000_0008, 1'b1, 2'd2, 4'b1111, 32'hCAFE_F00D),
                  mk_res(32'h0000_8001, 1'b0, 1'b0, 32'h0, 1'b0));

    $display("[TB] flush in WAIT drains");
    d0 = done_count;
    req_q.push_back(mk_bus(32'h0000_0010, 1'b0, 2'd2, 4'b0000, 32'h0));
    req_valid = 1'b1; mem_op = LW; addr = 32'h8000_0010; wdata = 32'h0;
    cycle();
    bus.data_sram_addr_ok = 1'b1;
    cycle();
    bus.data_sram_addr_ok = 1'b0;
    flush = 1'b1; req_valid = 1'b0;
    cycle();
    flush = 1'b0;
    @(negedge clk);
    checkOutput("drain_busy", {159'h0, busy}, 160'h1);
    cycle();
    bus.data_sram_data_ok = 1'b1; bus.data_sram_rdata = 32'hDEAD_BEEF;
    cycle();
    bus.data_sram_data_ok = 1'b0;
    @(negedge clk);
    checkOutput("drain_exit_busy", {159'h0, busy}, 160'h0);
    checkOutput("drain_rdata_kept", rdata_ext, 32'h0000_8001);
    checkOutput("drain_no_done", done_count - d0, 0);
    cycle();

    $display("[TB] flush in REQ drops the request");
    d0 = done_count;
    req_q.push_back(mk_bus(32'h0000_0020, 1'b0, 2'd2, 4'b0000, 32'h0));
    req_valid = 1'b1; mem_op = LW; addr = 32'h8000_0020;
    cycle();
    flush = 1'b1; req_valid = 1'b0;
    cycle();
    flush = 1'b0;
    if (req_q.size() > 0) b0 = int'(req_q.size()) - 1;
    if (req_q.size() > 0) void'(req_q.pop_front());
    @(negedge clk);
    checkOutput("flush_req_dropped", {bus.data_sram_req, busy}, 160'h0);
    repeat (3) cycle();
    checkOutput("flush_req_no_done", done_count - d0, 0);

    $display("[TB] reset in WAIT");
    req_q.push_back(mk_bus(32'h0000_0001, 1'b1, 2'd0, 4'b0010, 32'hA5A5_A5A5));
    req_valid = 1'b1; mem_op = SB; addr = 32'h8000_0001; wdata = 32'h0000_00A5;
    cycle();
    bus.data_sram_addr_ok = 1'b1;
    cycle();
    bus.data_sram_addr_ok = 1'b0;
    #2;
    resetn = 1'b0; req_valid = 1'b0;
    #1;
    checkOutput("async_reset_outputs", all_outs, 160'h0);
    cycle();
    cycle();
    resetn = 1'b1;
    cycle();
    applyStimulus(SB, 32'h8000_0001, 32'h0000_00A5, 0, 0, 32'h0, 1'b1,
                  mk_bus(32'h0000_0001, 1'b1, 2'd0, 4'b0010, 32'hA5A5_A5A5),
                  mk_res(32'h0000_0000, 1'b0, 1'b0, 32'h0, 1'b0));

    $display("[TB] address mask");
    applyStimulus(LW, 32'h9FFF_FFFC, 32'h0, 1, 0, 32'h1234_5678, 1'b1,
                  mk_bus(32'h1FFF_FFFC, 1'b0, 2'd2, 4'b0000, 32'h0),
                  mk_res(32'h1234_5678, 1'b0, 1'b0, 32'h0, 1'b0));

    repeat (3) cycle();
    checkOutput("req_queue_empty", req_q.size(), 0);
    checkOutput("result_queue_empty", res_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
